// File: rtl/imem_responder.sv
// imem_responder: two-entry instruction word buffer for the fetch unit.
// Fills misses over a single-ported 16-bit ready-handshake bus.
//
// Ports:
//   clk          system clock, rising edge
//   a_rst        asynchronous reset, active low
//   pc_addr      instruction address (bit 0 ignored)
//   pf_addr      prefetch address (bit 0 ignored)
//   fetch_en     fetch unit wants valid words this cycle
//   flush        invalidate both buffer entries
//   fetch_opc    buffered word at pc_addr, RESET_WORD on miss
//   prefetch_opc buffered word at pf_addr, RESET_WORD on miss
//   hold         stall: words not yet valid
//   mem_addr     external bus word address (bit 0 always 0)
//   mem_rd       external read request
//   mem_rdata    external read data, valid with mem_ready
//   mem_ready    external bus completes the current read
module imem_responder #(
    parameter logic [15:0] RESET_WORD = 16'h0000
) (
    input  logic        clk,
    input  logic        a_rst,
    input  logic [15:0] pc_addr,
    input  logic [15:0] pf_addr,
    input  logic        fetch_en,
    input  logic        flush,
    output logic [15:0] fetch_opc,
    output logic [15:0] prefetch_opc,
    output logic        hold,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RD_PC = 2'd1;
    localparam logic [1:0] S_RD_PF = 2'd2;

    logic [1:0]  r_state;
    logic        r_v0;
    logic        r_v1;
    logic [14:0] r_t0;
    logic [14:0] r_t1;
    logic [15:0] r_d0;
    logic [15:0] r_d1;
    logic [14:0] r_lat_pc;
    logic [14:0] r_lat_pf;
    logic        r_pf_hit_lat;
    // A flush hit the bus cycle in flight; its data must be dropped.
    logic        r_drop;

    logic [14:0] w_pc_tag;
    logic [14:0] w_pf_tag;
    logic        w_pc_h0;
    logic        w_pc_h1;
    logic        w_pf_h0;
    logic        w_pf_h1;
    logic        w_pc_hit;
    logic        w_pf_hit;
    logic        w_need;
    logic        w_busy;
    logic        w_fill;
    logic        w_fill_e1;
    logic [14:0] w_fill_tag;
    logic [14:0] w_keep_tag;
    logic        w_unused_lsb;

    assign w_pc_tag     = pc_addr[15:1];
    assign w_pf_tag     = pf_addr[15:1];
    assign w_unused_lsb = pc_addr[0] ^ pf_addr[0];

    assign w_pc_h0  = r_v0 & (r_t0 == w_pc_tag);
    assign w_pc_h1  = r_v1 & (r_t1 == w_pc_tag);
    assign w_pf_h0  = r_v0 & (r_t0 == w_pf_tag);
    assign w_pf_h1  = r_v1 & (r_t1 == w_pf_tag);
    assign w_pc_hit = w_pc_h0 | w_pc_h1;
    assign w_pf_hit = w_pf_h0 | w_pf_h1;
    assign w_need   = ~w_pc_hit | ~w_pf_hit;
    assign w_busy   = (r_state != S_IDLE);

    // E0 wins when both entries hold the same tag.
    assign fetch_opc    = w_pc_h0 ? r_d0 :
                          w_pc_h1 ? r_d1 : RESET_WORD;
    assign prefetch_opc = w_pf_h0 ? r_d0 :
                          w_pf_h1 ? r_d1 : RESET_WORD;

    // A flush in IDLE also stalls: the hits shown this cycle die at the edge.
    assign hold = w_busy | (fetch_en & (flush | w_need));

    always_comb begin
        mem_rd   = 1'b0;
        mem_addr = 16'h0000;
        unique case (r_state)
            S_RD_PC: begin
                mem_rd   = 1'b1;
                mem_addr = {r_lat_pc, 1'b0};
            end
            S_RD_PF: begin
                mem_rd   = 1'b1;
                mem_addr = {r_lat_pf, 1'b0};
            end
            default: begin
                mem_rd   = 1'b0;
                mem_addr = 16'h0000;
            end
        endcase
    end

    // The fill goes to whichever entry does not hold the other latched word,
    // so the pair fetched together never evicts itself.
    assign w_fill_tag = (r_state == S_RD_PC) ? r_lat_pc : r_lat_pf;
    assign w_keep_tag = (r_state == S_RD_PC) ? r_lat_pf : r_lat_pc;
    assign w_fill_e1  = r_v0 & (r_t0 == w_keep_tag);
    assign w_fill     = w_busy & mem_ready & ~flush & ~r_drop;

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            r_state      <= S_IDLE;
            r_v0         <= 1'b0;
            r_v1         <= 1'b0;
            r_t0         <= '0;
            r_t1         <= '0;
            r_d0         <= '0;
            r_d1         <= '0;
            r_lat_pc     <= '0;
            r_lat_pf     <= '0;
            r_pf_hit_lat <= 1'b0;
            r_drop       <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (fetch_en & ~flush & w_need) begin
                        r_lat_pc     <= w_pc_tag;
                        r_lat_pf     <= w_pf_tag;
                        r_pf_hit_lat <= w_pf_hit;
                        r_state      <= w_pc_hit ? S_RD_PF : S_RD_PC;
                    end
                end
                S_RD_PC: begin
                    if (mem_ready) begin
                        r_drop <= 1'b0;
                        if (flush | r_drop)
                            r_state <= S_IDLE;
                        else if ((r_lat_pf != r_lat_pc) & ~r_pf_hit_lat)
                            r_state <= S_RD_PF;
                        else
                            r_state <= S_IDLE;
                    end else if (flush) begin
                        r_drop <= 1'b1;
                    end
                end
                S_RD_PF: begin
                    if (mem_ready) begin
                        r_drop  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (flush) begin
                        r_drop <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (flush) begin
                r_v0 <= 1'b0;
                r_v1 <= 1'b0;
            end else if (w_fill) begin
                if (w_fill_e1) begin
                    r_v1 <= 1'b1;
                    r_t1 <= w_fill_tag;
                    r_d1 <= mem_rdata;
                end else begin
                    r_v0 <= 1'b1;
                    r_t0 <= w_fill_tag;
                    r_d0 <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: table-driven fetch requests plus bus-address scoreboard
// and hand sequences for stalls, flush and reset mid-cycle.
module tb_imem_responder;

    logic        clk = 1'b0;
    logic        a_rst;
    logic [15:0] pc_addr;
    logic [15:0] pf_addr;
    logic        fetch_en;
    logic        flush;
    logic [15:0] fetch_opc;
    logic [15:0] prefetch_opc;
    logic        hold;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [15:0] mem_rdata;
    logic        mem_ready;

    imem_responder #(.RESET_WORD(16'h0000)) dut (
        .clk          (clk),
        .a_rst        (a_rst),
        .pc_addr      (pc_addr),
        .pf_addr      (pf_addr),
        .fetch_en     (fetch_en),
        .flush        (flush),
        .fetch_opc    (fetch_opc),
        .prefetch_opc (prefetch_opc),
        .hold         (hold),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        case (a)
            16'h0100: mem_word = 16'hA900;
            16'h0102: mem_word = 16'h1234;
            default:  mem_word = a ^ 16'hC3A5;
        endcase
    endfunction

    always_comb mem_rdata = mem_word(mem_addr);

    int n_chk  = 0;
    int n_pass = 0;
    int rd_cnt = 0;
    logic [15:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic bus_mon();
        logic [15:0] e;
        if (mem_rd && mem_ready) begin
            rd_cnt++;
            if (exp_q.size() == 0) begin
                chk("bus_unexpected_read", {16'h0, mem_addr}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("bus_addr", {16'h0, mem_addr}, {16'h0, e});
            end
        end
    endtask

    task automatic tick();
        #1;
        bus_mon();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string       name;
        logic [15:0] pc;
        logic [15:0] pf;
        int          holds;
        int          nrd;
        logic [15:0] a0;
        logic [15:0] a1;
        logic [15:0] ef;
        logic [15:0] ep;
    } vec_t;

    task automatic run_req(input vec_t v);
        int n;
        int r0;
        pc_addr  = v.pc;
        pf_addr  = v.pf;
        fetch_en = 1'b1;
        if (v.nrd > 0) exp_q.push_back(v.a0);
        if (v.nrd > 1) exp_q.push_back(v.a1);
        r0 = rd_cnt;
        #1;
        n = 0;
        while (hold && n <= 20) begin
            n++;
            tick();
        end
        chk({v.name, "_hold_cycles"}, n, v.holds);
        chk({v.name, "_reads"}, rd_cnt - r0, v.nrd);
        chk({v.name, "_fetch_opc"}, {16'h0, fetch_opc}, {16'h0, v.ef});
        chk({v.name, "_prefetch_opc"}, {16'h0, prefetch_opc}, {16'h0, v.ep});
        chk({v.name, "_scoreboard_empty"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    vec_t vt[7];

    initial begin
        vt[0] = '{"t1_both_miss", 16'h0100, 16'h0102, 3, 2, 16'h0100,
                  16'h0102, 16'hA900, 16'h1234};
        vt[1] = '{"t2_pf_miss", 16'h0102, 16'h0104, 2, 1, 16'h0104,
                  16'h0000, 16'h1234, mem_word(16'h0104)};
        vt[2] = '{"both_hit", 16'h0104, 16'h0102, 0, 0, 16'h0000,
                  16'h0000, mem_word(16'h0104), 16'h1234};
        vt[3] = '{"t3_same_word", 16'h0200, 16'h0200, 2, 1, 16'h0200,
                  16'h0000, mem_word(16'h0200), mem_word(16'h0200)};
        vt[4] = '{"bit0_ignored", 16'h0201, 16'h0200, 0, 0, 16'h0000,
                  16'h0000, mem_word(16'h0200), mem_word(16'h0200)};
        vt[5] = '{"e1_retained", 16'h0102, 16'h0200, 0, 0, 16'h0000,
                  16'h0000, 16'h1234, mem_word(16'h0200)};
        vt[6] = '{"both_miss2", 16'h0300, 16'h0302, 3, 2, 16'h0300,
                  16'h0302, mem_word(16'h0300), mem_word(16'h0302)};

        a_rst     = 1'b0;
        pc_addr   = 16'h0100;
        pf_addr   = 16'h0102;
        fetch_en  = 1'b0;
        flush     = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("rst_hold_idle", {31'h0, hold}, 32'h0);
        chk("rst_mem_rd", {31'h0, mem_rd}, 32'h0);
        chk("rst_mem_addr", {16'h0, mem_addr}, 32'h0);
        chk("rst_fetch_opc", {16'h0, fetch_opc}, 32'h0);
        chk("rst_prefetch_opc", {16'h0, prefetch_opc}, 32'h0);
        fetch_en = 1'b1;
        #1;
        chk("rst_hold_fetch_en", {31'h0, hold}, 32'h1);
        fetch_en = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        a_rst = 1'b1;
        #1;
        chk("idle_ready_ignored", {30'h0, mem_rd, hold}, 32'h0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) run_req(vt[i]);

        // Stalled bus: four not-ready cycles, request must stay stable.
        pc_addr   = 16'h0400;
        pf_addr   = 16'h0400;
        mem_ready = 1'b0;
        #1;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t4_stall_bus", {14'h0, mem_rd, hold, mem_addr},
                {14'h0, 1'b1, 1'b1, 16'h0400});
            tick();
        end
        mem_ready = 1'b1;
        exp_q.push_back(16'h0400);
        tick();
        chk("t4_fill_hold", {31'h0, hold}, 32'h0);
        chk("t4_fill_data", {16'h0, fetch_opc}, {16'h0, mem_word(16'h0400)});
        chk("t4_scoreboard", exp_q.size(), 0);
        exp_q.delete();

        // Flush while RD_PC waits for the bus.
        pc_addr   = 16'h0500;
        pf_addr   = 16'h0500;
        mem_ready = 1'b0;
        #1;
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("t5_rd_kept", {15'h0, mem_rd, mem_addr}, {15'h0, 1'b1, 16'h0500});
        tick();
        chk("t5_rd_kept2", {31'h0, mem_rd}, 32'h1);
        mem_ready = 1'b1;
        exp_q.push_back(16'h0500);
        tick();
        chk("t5_idle", {31'h0, mem_rd}, 32'h0);
        chk("t5_dropped_hold", {31'h0, hold}, 32'h1);
        chk("t5_dropped_data", {16'h0, fetch_opc}, 32'h0);
        pc_addr = 16'h0400;
        pf_addr = 16'h0400;
        #1;
        chk("t5_old_entry_gone", {15'h0, hold, fetch_opc}, {15'h0, 1'b1, 16'h0});
        fetch_en = 1'b0;
        #1;
        chk("t5_idle_no_fetch", {31'h0, hold}, 32'h0);
        chk("t5_scoreboard", exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk);
        #1;

        // Reset in the middle of RD_PF.
        pc_addr  = 16'h0600;
        pf_addr  = 16'h0602;
        fetch_en = 1'b1;
        exp_q.push_back(16'h0600);
        #1;
        tick();
        tick();
        chk("t6_in_rd_pf", {15'h0, mem_rd, mem_addr}, {15'h0, 1'b1, 16'h0602});
        a_rst = 1'b0;
        #1;
        chk("t6_rst_bus", {15'h0, mem_rd, mem_addr}, 32'h0);
        chk("t6_rst_words", {fetch_opc, prefetch_opc}, 32'h0);
        chk("t6_rst_hold", {31'h0, hold}, 32'h1);
        exp_q.delete();
        @(posedge clk);
        #1;
        a_rst = 1'b1;
        run_req('{"t6_restart", 16'h0600, 16'h0602, 3, 2, 16'h0600,
                  16'h0602, mem_word(16'h0600), mem_word(16'h0602)});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
